// File: rtl/dac_mon_pkg.sv
// Shared definitions for the DAC link monitor: FSM state encoding and
// AXI write-response constants.
package dac_mon_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned BRESP_W = 2;

  // AXI OKAY response; any other bresp value counts as an error.
  localparam logic [BRESP_W-1:0] BRESP_OKAY = 2'b00;

  // Encodings are visible on the state output port.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_RST  = 3'd1,
    ST_WAIT_ARDY = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_CHECK     = 3'd4,
    ST_DONE      = 3'd5,
    ST_FAIL      = 3'd6
  } state_e;

endpackage : dac_mon_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   clr_i   - synchronous clear; wins over inc_i
//   inc_i   - increment request
//   count_o - registered count, holds at all-ones
module sat_counter
  import dac_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear has priority, increment stops at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter

// File: rtl/dac_link_monitor.sv
// Passive monitor for a DAC configuration link. Observes AXI-Lite write
// traffic and the DAC sample bus, keeps saturating activity counters and
// sticky lane flags, and runs a bring-up check sequence:
// wait for transceiver reset-done edge, wait for DAC arready, settle,
// then pass if both writes and data were seen.
// Ports:
//   sys_clk, sys_rst_n          - clock, async active-low reset
//   start, clear                - arm check sequence / zero all monitor state
//   aw*, w*, b*                 - observed AXI-Lite write channel
//   arready, tx_reset_done      - DAC core ready, transceiver reset-done
//   tdata                       - DAC sample bus, NUM_LANES x LANE_W
//   wr_count, bresp_err_count,
//   beat_count                  - saturating activity counters
//   lane_active                 - sticky per-lane nonzero flags
//   last_awaddr, last_wdata     - last accepted write address / data
//   state, cfg_done, err_*      - sequence state, pass flag, failure causes
module dac_link_monitor
  import dac_mon_pkg::*;
#(
  parameter int unsigned NUM_LANES   = 8,
  parameter int unsigned LANE_W      = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned SETTLE_CYC  = 50,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        start,
  input  logic                        clear,
  input  logic                        awvalid,
  input  logic                        awready,
  input  logic [ADDR_W-1:0]           awaddr,
  input  logic                        wvalid,
  input  logic                        wready,
  input  logic [31:0]                 wdata,
  input  logic                        bvalid,
  input  logic                        bready,
  input  logic [1:0]                  bresp,
  input  logic                        arready,
  input  logic                        tx_reset_done,
  input  logic [NUM_LANES*LANE_W-1:0] tdata,
  output logic [CNT_W-1:0]            wr_count,
  output logic [CNT_W-1:0]            bresp_err_count,
  output logic [CNT_W-1:0]            beat_count,
  output logic [NUM_LANES-1:0]        lane_active,
  output logic [ADDR_W-1:0]           last_awaddr,
  output logic [31:0]                 last_wdata,
  output logic [2:0]                  state,
  output logic                        cfg_done,
  output logic                        err_no_write,
  output logic                        err_no_data,
  output logic                        err_timeout
);

  // Dwell counter must reach the larger of the two wait limits.
  localparam int unsigned DWELL_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int unsigned DWELL_W   = $clog2(DWELL_MAX + 1);
  // Dwell reads 0 on the first cycle in a state, so the last cycle is N-1.
  localparam logic [DWELL_W-1:0] SETTLE_LAST  = DWELL_W'(SETTLE_CYC - 1);
  localparam logic [DWELL_W-1:0] TIMEOUT_LAST = DWELL_W'(TIMEOUT_CYC - 1);

  state_e               state_q;
  state_e               state_d;
  logic [DWELL_W-1:0]   dwell_q;
  logic                 dwell_clr;
  logic                 tx_done_q;
  logic                 tx_done_rise;
  logic [NUM_LANES-1:0] lane_nz;
  logic [NUM_LANES-1:0] lane_active_q;
  logic [ADDR_W-1:0]    last_awaddr_q;
  logic [31:0]          last_wdata_q;
  logic                 cfg_done_q;
  logic                 err_no_write_q;
  logic                 err_no_data_q;
  logic                 err_timeout_q;
  logic                 set_no_write;
  logic                 set_no_data;
  logic                 set_timeout;
  logic                 aw_hs;
  logic                 w_hs;
  logic                 b_err;
  logic [CNT_W-1:0]     wr_count_q;
  logic [CNT_W-1:0]     bresp_err_count_q;
  logic [CNT_W-1:0]     beat_count_q;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_err = bvalid && bready && (bresp != BRESP_OKAY);

  // Per-lane nonzero detect.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lane_nz[k] = |tdata[k*LANE_W +: LANE_W];
  end

  // Rising edge against the previous cycle's level; a level high on entry
  // to WAIT_RST never produces an edge.
  assign tx_done_rise = tx_reset_done && !tx_done_q;

  // Activity counters; clear wins over a coincident qualifying event.
  sat_counter #(.WIDTH(CNT_W)) u_wr_cnt (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .clr_i   (clear),
    .inc_i   (w_hs),
    .count_o (wr_count_q)
  );

  sat_counter #(.WIDTH(CNT_W)) u_berr_cnt (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .clr_i   (clear),
    .inc_i   (b_err),
    .count_o (bresp_err_count_q)
  );

  sat_counter #(.WIDTH(CNT_W)) u_beat_cnt (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .clr_i   (clear),
    .inc_i   (|lane_nz),
    .count_o (beat_count_q)
  );

  // Cycles spent in the current state; reloads on every state change.
  assign dwell_clr = (state_d != state_q);

  sat_counter #(.WIDTH(DWELL_W)) u_dwell_cnt (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .clr_i   (dwell_clr),
    .inc_i   (1'b1),
    .count_o (dwell_q)
  );

  // Next-state and error-set decode. A qualifying event on the last
  // allowed cycle of a wait beats the timeout.
  always_comb begin
    state_d      = state_q;
    set_no_write = 1'b0;
    set_no_data  = 1'b0;
    set_timeout  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_WAIT_RST;
      end
      ST_WAIT_RST: begin
        if (tx_done_rise) begin
          state_d = ST_WAIT_ARDY;
        end else if (dwell_q == TIMEOUT_LAST) begin
          state_d     = ST_FAIL;
          set_timeout = 1'b1;
        end
      end
      ST_WAIT_ARDY: begin
        if (arready) begin
          state_d = ST_SETTLE;
        end else if (dwell_q == TIMEOUT_LAST) begin
          state_d     = ST_FAIL;
          set_timeout = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (dwell_q == SETTLE_LAST) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if ((wr_count_q != '0) && (beat_count_q != '0)) begin
          state_d = ST_DONE;
        end else begin
          state_d      = ST_FAIL;
          set_no_write = (wr_count_q == '0);
          set_no_data  = (beat_count_q == '0);
        end
      end
      ST_DONE, ST_FAIL: begin
        if (start) state_d = ST_WAIT_RST;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d      = ST_IDLE;
      set_no_write = 1'b0;
      set_no_data  = 1'b0;
      set_timeout  = 1'b0;
    end
  end

  // State, sticky flags and capture registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= ST_IDLE;
      tx_done_q      <= 1'b0;
      cfg_done_q     <= 1'b0;
      err_no_write_q <= 1'b0;
      err_no_data_q  <= 1'b0;
      err_timeout_q  <= 1'b0;
      lane_active_q  <= '0;
      last_awaddr_q  <= '0;
      last_wdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      tx_done_q  <= tx_reset_done;
      cfg_done_q <= (state_d == ST_DONE);
      if (clear) begin
        err_no_write_q <= 1'b0;
        err_no_data_q  <= 1'b0;
        err_timeout_q  <= 1'b0;
        lane_active_q  <= '0;
        last_awaddr_q  <= '0;
        last_wdata_q   <= '0;
      end else begin
        err_no_write_q <= err_no_write_q | set_no_write;
        err_no_data_q  <= err_no_data_q | set_no_data;
        err_timeout_q  <= err_timeout_q | set_timeout;
        lane_active_q  <= lane_active_q | lane_nz;
        if (aw_hs) last_awaddr_q <= awaddr;
        if (w_hs)  last_wdata_q  <= wdata;
      end
    end
  end

  assign wr_count        = wr_count_q;
  assign bresp_err_count = bresp_err_count_q;
  assign beat_count      = beat_count_q;
  assign lane_active     = lane_active_q;
  assign last_awaddr     = last_awaddr_q;
  assign last_wdata      = last_wdata_q;
  assign state           = state_q;
  assign cfg_done        = cfg_done_q;
  assign err_no_write    = err_no_write_q;
  assign err_no_data     = err_no_data_q;
  assign err_timeout     = err_timeout_q;

endmodule : dac_link_monitor
